// File: rtl/bcedn_pkg.sv
// Shared definitions for the BCEDN result checker: result stream geometry,
// checker state encoding and the bit positions inside err_flags.
package bcedn_pkg;

   localparam int BCEDN_RES_W     = 24;
   localparam int BCEDN_RES_COUNT = 110592;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_PASS  = 3'd3,
      ST_FAIL  = 3'd4
   } state_e;

   localparam int FLAG_UNDERRUN = 0;
   localparam int FLAG_OVERRUN  = 1;
   localparam int FLAG_TIMEOUT  = 2;

endpackage

// File: rtl/bcedn_cmp_stage.sv
// Second pipeline stage of the result checker: compares the latched result
// word with the golden word, keeps a saturating mismatch count and records
// the index and both words of the first mismatch seen in a run.
module bcedn_cmp_stage #(
   parameter int DATA_W = 24,
   parameter int IDX_W  = 18,
   parameter int ERR_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              v1_i,
   input  logic [DATA_W-1:0] d1_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [DATA_W-1:0] rom_dout_i,
   output logic [ERR_W-1:0]  err_count_o,
   output logic [IDX_W-1:0]  first_err_idx_o,
   output logic [DATA_W-1:0] first_err_got_o,
   output logic [DATA_W-1:0] first_err_exp_o
);

   logic [ERR_W-1:0]  errCnt_q, errCnt_d;
   logic              haveErr_q, haveErr_d;
   logic [IDX_W-1:0]  firstIdx_q, firstIdx_d;
   logic [DATA_W-1:0] firstGot_q, firstGot_d;
   logic [DATA_W-1:0] firstExp_q, firstExp_d;
   logic              mismatch;

   assign mismatch = v1_i && (d1_i != rom_dout_i);

   // Next error state: clear at run start, else count mismatches and grab the first one
   always_comb begin
      errCnt_d   = errCnt_q;
      haveErr_d  = haveErr_q;
      firstIdx_d = firstIdx_q;
      firstGot_d = firstGot_q;
      firstExp_d = firstExp_q;
      if (clear_i) begin
         errCnt_d   = '0;
         haveErr_d  = 1'b0;
         firstIdx_d = '0;
         firstGot_d = '0;
         firstExp_d = '0;
      end else if (mismatch) begin
         if (errCnt_q != '1) begin
            errCnt_d = errCnt_q + ERR_W'(1);
         end
         if (!haveErr_q) begin
            haveErr_d  = 1'b1;
            firstIdx_d = idx_i;
            firstGot_d = d1_i;
            firstExp_d = rom_dout_i;
         end
      end
   end

   // Error bookkeeping registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         errCnt_q   <= '0;
         haveErr_q  <= 1'b0;
         firstIdx_q <= '0;
         firstGot_q <= '0;
         firstExp_q <= '0;
      end else begin
         errCnt_q   <= errCnt_d;
         haveErr_q  <= haveErr_d;
         firstIdx_q <= firstIdx_d;
         firstGot_q <= firstGot_d;
         firstExp_q <= firstExp_d;
      end
   end

   assign err_count_o     = errCnt_q;
   assign first_err_idx_o = firstIdx_q;
   assign first_err_got_o = firstGot_q;
   assign first_err_exp_o = firstExp_q;

endmodule

// File: rtl/bcedn_result_checker.sv
// Checks the BCEDN_TOP result stream against a golden ROM, tracks sample and
// mismatch counts, detects short/long streams and stalls, and reports a
// sticky pass/fail verdict for the board LEDs.
module bcedn_result_checker
   import bcedn_pkg::*;
#(
   parameter int DATA_W    = BCEDN_RES_W,
   parameter int EXP_COUNT = BCEDN_RES_COUNT,
   parameter int ADDR_W    = 17,
   parameter int ERR_W     = 16,
   parameter int TIMEOUT   = 1 << 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] res_data,
   input  logic              res_en,
   input  logic              dut_done,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_dout,
   output logic              busy,
   output logic              pass,
   output logic              fail,
   output logic [ADDR_W:0]   sample_count,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W:0]   first_err_idx,
   output logic [DATA_W-1:0] first_err_got,
   output logic [DATA_W-1:0] first_err_exp,
   output logic [2:0]        err_flags
);

   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W:0] EXP_CNT = (ADDR_W + 1)'(EXP_COUNT);
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

   state_e            state_q, state_d;
   logic [1:0]        rstSync_q;
   logic              rstInt_n;
   logic [ADDR_W:0]   sampleCnt_q, sampleCnt_d;
   logic [TO_W-1:0]   idleCnt_q, idleCnt_d;
   logic [2:0]        errFlags_q, errFlags_d;
   logic              v1_q, v1_d;
   logic [DATA_W-1:0] d1_q, d1_d;
   logic [ADDR_W:0]   idx1_q, idx1_d;
   logic              armStart, inRun, wordIn, accept, timeoutHit;

   // Reset asserts asynchronously but is released in step with clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rstSync_q <= 2'b00;
      end else begin
         rstSync_q <= {rstSync_q[0], 1'b1};
      end
   end

   assign rstInt_n = rstSync_q[1];

   assign inRun      = (state_q == ST_RUN);
   assign armStart   = start && (state_q == ST_IDLE || state_q == ST_PASS || state_q == ST_FAIL);
   assign wordIn     = res_en && (inRun || state_q == ST_DRAIN);
   assign accept     = res_en && inRun && (sampleCnt_q < EXP_CNT);
   assign timeoutHit = inRun && !res_en && (idleCnt_q == TO_W'(TIMEOUT - 1));

   // Stage 0 and run counters: latch accepted words, count samples, raise error flags
   always_comb begin
      sampleCnt_d = sampleCnt_q;
      idleCnt_d   = idleCnt_q;
      errFlags_d  = errFlags_q;
      v1_d        = accept;
      d1_d        = d1_q;
      idx1_d      = idx1_q;
      if (armStart) begin
         sampleCnt_d = '0;
         idleCnt_d   = '0;
         errFlags_d  = '0;
      end else begin
         if (wordIn && sampleCnt_q != '1) begin
            sampleCnt_d = sampleCnt_q + CNT_ONE;
         end
         if (inRun) begin
            idleCnt_d = res_en ? '0 : idleCnt_q + TO_W'(1);
         end
         if (wordIn && !accept) begin
            errFlags_d[FLAG_OVERRUN] = 1'b1;
         end
         if (inRun && dut_done && sampleCnt_d < EXP_CNT) begin
            errFlags_d[FLAG_UNDERRUN] = 1'b1;
         end
         if (timeoutHit) begin
            errFlags_d[FLAG_TIMEOUT] = 1'b1;
         end
      end
      if (accept) begin
         d1_d   = res_data;
         idx1_d = sampleCnt_q;
      end
   end

   // Run counters and stage-0 pipeline registers
   always_ff @(posedge clk or negedge rstInt_n) begin
      if (!rstInt_n) begin
         sampleCnt_q <= '0;
         idleCnt_q   <= '0;
         errFlags_q  <= '0;
         v1_q        <= 1'b0;
         d1_q        <= '0;
         idx1_q      <= '0;
      end else begin
         sampleCnt_q <= sampleCnt_d;
         idleCnt_q   <= idleCnt_d;
         errFlags_q  <= errFlags_d;
         v1_q        <= v1_d;
         d1_q        <= d1_d;
         idx1_q      <= idx1_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rstInt_n) begin
      if (!rstInt_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: verdict is taken once the compare stage holds no word
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_PASS, ST_FAIL: begin
            if (start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (dut_done || timeoutHit) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!v1_q) begin
               state_d = (err_count == '0 && errFlags_d == 3'b000) ? ST_PASS : ST_FAIL;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs and ROM read port
   always_comb begin
      busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      pass     = (state_q == ST_PASS);
      fail     = (state_q == ST_FAIL);
      rom_en   = accept;
      rom_addr = sampleCnt_q[ADDR_W-1:0];
   end

   assign sample_count = sampleCnt_q;
   assign err_flags    = errFlags_q;

   bcedn_cmp_stage #(
      .DATA_W(DATA_W),
      .IDX_W (ADDR_W + 1),
      .ERR_W (ERR_W)
   ) uCmpStage (
      .clk            (clk),
      .rst_n          (rstInt_n),
      .clear_i        (armStart),
      .v1_i           (v1_q),
      .d1_i           (d1_q),
      .idx_i          (idx1_q),
      .rom_dout_i     (rom_dout),
      .err_count_o    (err_count),
      .first_err_idx_o(first_err_idx),
      .first_err_got_o(first_err_got),
      .first_err_exp_o(first_err_exp)
   );

endmodule

// File: tb/tb_bcedn_result_checker.sv
// Directed bench for bcedn_result_checker with a small run length and a
// short stall limit, driving result streams against a modelled golden ROM.
module tb_bcedn_result_checker;

   localparam int DATA_W    = 24;
   localparam int EXP_COUNT = 16;
   localparam int ADDR_W    = 5;
   localparam int ERR_W     = 16;
   localparam int TIMEOUT   = 64;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [DATA_W-1:0] res_data;
   logic              res_en;
   logic              dut_done;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_dout;
   logic              busy;
   logic              pass;
   logic              fail;
   logic [ADDR_W:0]   sample_count;
   logic [ERR_W-1:0]  err_count;
   logic [ADDR_W:0]   first_err_idx;
   logic [DATA_W-1:0] first_err_got;
   logic [DATA_W-1:0] first_err_exp;
   logic [2:0]        err_flags;

   logic [DATA_W-1:0] rom [32];
   logic              romEnLast;
   logic              romEnAt [32];
   int                vecCount  = 0;
   int                missCount = 0;

   bcedn_result_checker #(
      .DATA_W   (DATA_W),
      .EXP_COUNT(EXP_COUNT),
      .ADDR_W   (ADDR_W),
      .ERR_W    (ERR_W),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .res_data     (res_data),
      .res_en       (res_en),
      .dut_done     (dut_done),
      .rom_en       (rom_en),
      .rom_addr     (rom_addr),
      .rom_dout     (rom_dout),
      .busy         (busy),
      .pass         (pass),
      .fail         (fail),
      .sample_count (sample_count),
      .err_count    (err_count),
      .first_err_idx(first_err_idx),
      .first_err_got(first_err_got),
      .first_err_exp(first_err_exp),
      .err_flags    (err_flags)
   );

   always #5 clk = ~clk;

   // Golden ROM with one cycle of read latency
   always @(posedge clk) begin
      if (rom_en) begin
         rom_dout <= rom[rom_addr];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vecCount++;
      assert (observed === expected) else begin
         missCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One clock cycle of input; returns 1 time unit after the sampling edge
   task automatic applyStimulus(input logic s, input logic en, input logic dn, input logic [DATA_W-1:0] data);
      start    = s;
      res_en   = en;
      dut_done = dn;
      res_data = data;
      #2;
      romEnLast = rom_en;
      @(posedge clk);
      #1;
      start    = 1'b0;
      res_en   = 1'b0;
      dut_done = 1'b0;
      res_data = '0;
   endtask

   task automatic waitEnd();
      for (int k = 0; k < 3; k++) begin
         if (pass || fail) break;
         applyStimulus(1'b0, 1'b0, 1'b0, '0);
      end
   endtask

   task automatic doRun(input int nWords, input int badIdx, input logic doneWithLast);
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < nWords; i++) begin
         applyStimulus(1'b0, 1'b1, doneWithLast && (i == nWords - 1),
                       (i == badIdx) ? 24'hABCDEF : rom[i]);
         romEnAt[i] = romEnLast;
      end
      if (!doneWithLast) begin
         applyStimulus(1'b0, 1'b0, 1'b1, '0);
      end
      waitEnd();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rom[i] = 24'h000100 + 24'(i * 7);
      end
      rom_dout = '0;
      start    = 1'b0;
      res_en   = 1'b0;
      dut_done = 1'b0;
      res_data = '0;
      rst_n    = 1'b0;
      #2;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_pass_fail", {30'd0, pass, fail}, 32'd0);
      checkOutput("reset_rom_en", 32'(rom_en), 32'd0);
      checkOutput("reset_count", 32'(sample_count), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] clean run");
      doRun(16, -1, 1'b0);
      checkOutput("clean_pass", 32'(pass), 32'd1);
      checkOutput("clean_fail", 32'(fail), 32'd0);
      checkOutput("clean_err_count", 32'(err_count), 32'd0);
      checkOutput("clean_count", 32'(sample_count), 32'd16);
      checkOutput("clean_flags", 32'(err_flags), 32'd0);
      checkOutput("clean_busy", 32'(busy), 32'd0);
      checkOutput("clean_rom_en_15", 32'(romEnAt[15]), 32'd1);

      applyStimulus(1'b0, 1'b1, 1'b0, 24'h123456);
      checkOutput("idle_word_ignored_count", 32'(sample_count), 32'd16);
      checkOutput("idle_word_ignored_pass", 32'(pass), 32'd1);

      $display("[TB] single corruption");
      doRun(16, 5, 1'b0);
      checkOutput("corrupt_fail", 32'(fail), 32'd1);
      checkOutput("corrupt_pass", 32'(pass), 32'd0);
      checkOutput("corrupt_err_count", 32'(err_count), 32'd1);
      checkOutput("corrupt_idx", 32'(first_err_idx), 32'd5);
      checkOutput("corrupt_got", 32'(first_err_got), 32'hABCDEF);
      checkOutput("corrupt_exp", 32'(first_err_exp), 32'h000123);
      checkOutput("corrupt_flags", 32'(err_flags), 32'd0);

      $display("[TB] underrun");
      doRun(10, -1, 1'b0);
      checkOutput("under_fail", 32'(fail), 32'd1);
      checkOutput("under_flags", 32'(err_flags), 32'b001);
      checkOutput("under_count", 32'(sample_count), 32'd10);
      checkOutput("under_err_count", 32'(err_count), 32'd0);
      checkOutput("under_first_idx_cleared", 32'(first_err_idx), 32'd0);

      $display("[TB] overrun with done");
      doRun(17, -1, 1'b1);
      checkOutput("over_count", 32'(sample_count), 32'd17);
      checkOutput("over_flags", 32'(err_flags), 32'b010);
      checkOutput("over_rom_en_16", 32'(romEnAt[16]), 32'd0);
      checkOutput("over_rom_en_15", 32'(romEnAt[15]), 32'd1);
      checkOutput("over_fail", 32'(fail), 32'd1);
      checkOutput("over_err_count", 32'(err_count), 32'd0);

      $display("[TB] timeout");
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, rom[i]);
      end
      for (int k = 0; k < 63; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, '0);
      end
      checkOutput("to_flag_before", 32'(err_flags), 32'd0);
      checkOutput("to_busy_before", 32'(busy), 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkOutput("to_flag_at_64", 32'(err_flags), 32'b100);
      waitEnd();
      checkOutput("to_fail", 32'(fail), 32'd1);
      checkOutput("to_busy", 32'(busy), 32'd0);
      checkOutput("to_count", 32'(sample_count), 32'd3);

      $display("[TB] reset mid-run");
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, rom[i]);
      end
      checkOutput("mid_count_before", 32'(sample_count), 32'd8);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_count", 32'(sample_count), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_status", {29'd0, err_flags}, 32'd0);
      checkOutput("mid_rst_pass_fail", {30'd0, pass, fail}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("mid_idle_busy", 32'(busy), 32'd0);
      doRun(16, -1, 1'b0);
      checkOutput("mid_rerun_pass", 32'(pass), 32'd1);
      checkOutput("mid_rerun_count", 32'(sample_count), 32'd16);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
